// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multicycle instruction sequencer.
// The state encoding is visible on the state output, so these values are fixed.
package cpu_seq_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_REGREAD = 4'd3,
        ST_EXECUTE = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB      = 4'd6,
        ST_PCUPD   = 4'd7,
        ST_HALT    = 4'd8
    } state_t;

endpackage

// File: rtl/seq_wait_timer.sv
// Counts the cycles a memory request has waited for its ack.
// expired is high while the count sits at MAX_WAIT.
module seq_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(MAX_WAIT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Steps each instruction through fetch/decode/regread/execute/mem/wb/pc-update,
// with memory handshakes, timeout-to-halt, halt/run control and perf counters.
module multicycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int INSTR_W  = 8,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               halt_req,
    input  logic               clear_halt,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic               reg_w_en,
    output logic               decode_en,
    output logic               regread_en,
    output logic               execute_en,
    output logic               wb_en,
    output logic               pc_update_en,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic [3:0]         state,
    output logic               busy,
    output logic               halted,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   retired_count
);

    state_t cur_state;
    state_t next_state;
    logic   halt_pending;
    logic   wr_lat;
    logic   wen_lat;
    logic   set_timeout;
    logic   waiting;
    logic   awaited_ack;
    logic   timer_expired;

    assign waiting     = (cur_state == ST_FETCH) || (cur_state == ST_MEM);
    assign awaited_ack = (cur_state == ST_FETCH) ? imem_ack : dmem_ack;

    // Timer is held clear outside the wait states, so every entry starts at zero.
    seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!waiting),
        .inc     (waiting && !awaited_ack),
        .expired (timer_expired)
    );

    always_comb begin
        next_state  = cur_state;
        set_timeout = 1'b0;
        unique case (cur_state)
            ST_IDLE: begin
                if (halt_req || halt_pending) next_state = ST_HALT;
                else if (run)                 next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    next_state = ST_DECODE;
                end else if (timer_expired) begin
                    next_state  = ST_HALT;
                    set_timeout = 1'b1;
                end
            end
            ST_DECODE:  next_state = ST_REGREAD;
            ST_REGREAD: next_state = ST_EXECUTE;
            ST_EXECUTE: begin
                if (mem_rd || mem_wr) next_state = ST_MEM;
                else if (reg_w_en)    next_state = ST_WB;
                else                  next_state = ST_PCUPD;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    next_state = wen_lat ? ST_WB : ST_PCUPD;
                end else if (timer_expired) begin
                    next_state  = ST_HALT;
                    set_timeout = 1'b1;
                end
            end
            ST_WB: next_state = ST_PCUPD;
            ST_PCUPD: begin
                if (halt_pending) next_state = ST_HALT;
                else if (run)     next_state = ST_FETCH;
                else              next_state = ST_IDLE;
            end
            ST_HALT: begin
                if (clear_halt) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= ST_IDLE;
            instr_out     <= '0;
            wr_lat        <= 1'b0;
            wen_lat       <= 1'b0;
            halt_pending  <= 1'b0;
            timeout_err   <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            cur_state <= next_state;
            if (cur_state == ST_FETCH && imem_ack) instr_out <= instr_in;
            if (cur_state == ST_EXECUTE) begin
                wr_lat  <= mem_wr;
                wen_lat <= reg_w_en;
            end
            // A halt request is remembered until clear_halt; requests in HALT are ignored.
            if (cur_state == ST_HALT) begin
                if (clear_halt) halt_pending <= 1'b0;
            end else if (halt_req) begin
                halt_pending <= 1'b1;
            end
            if (set_timeout)                               timeout_err <= 1'b1;
            else if (cur_state == ST_HALT && clear_halt)   timeout_err <= 1'b0;
            if (busy)                   cycle_count   <= cycle_count + 1'b1;
            if (cur_state == ST_PCUPD)  retired_count <= retired_count + 1'b1;
        end
    end

    assign state        = cur_state;
    assign imem_req     = (cur_state == ST_FETCH);
    assign decode_en    = (cur_state == ST_DECODE);
    assign regread_en   = (cur_state == ST_REGREAD);
    assign execute_en   = (cur_state == ST_EXECUTE);
    assign wb_en        = (cur_state == ST_WB);
    assign pc_update_en = (cur_state == ST_PCUPD);
    assign dmem_req     = (cur_state == ST_MEM);
    assign dmem_we      = (cur_state == ST_MEM) && wr_lat;
    assign halted       = (cur_state == ST_HALT);
    assign busy         = (cur_state != ST_IDLE) && (cur_state != ST_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: expected per-cycle state traces are built from the
// stage rules (stage list plus wait lengths) and compared cycle by cycle.
module tb_multicycle_sequencer;

    localparam int INSTR_W  = 8;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 16;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_REGREAD = 4'd3, S_EXECUTE = 4'd4, S_MEM = 4'd5,
                           S_WB = 4'd6, S_PCUPD = 4'd7, S_HALT = 4'd8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               run, halt_req, clear_halt;
    logic               imem_req, imem_ack;
    logic [INSTR_W-1:0] instr_in, instr_out;
    logic               mem_rd, mem_wr, reg_w_en;
    logic               decode_en, regread_en, execute_en, wb_en, pc_update_en;
    logic               dmem_req, dmem_we, dmem_ack;
    logic [3:0]         state;
    logic               busy, halted, timeout_err;
    logic [CNT_W-1:0]   cycle_count, retired_count;

    int checks   = 0;
    int failures = 0;
    int exp_cycles;
    int exp_retired;

    multicycle_sequencer #(
        .INSTR_W (INSTR_W), .MAX_WAIT (MAX_WAIT), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .run (run), .halt_req (halt_req),
        .clear_halt (clear_halt), .imem_req (imem_req), .imem_ack (imem_ack),
        .instr_in (instr_in), .instr_out (instr_out), .mem_rd (mem_rd),
        .mem_wr (mem_wr), .reg_w_en (reg_w_en), .decode_en (decode_en),
        .regread_en (regread_en), .execute_en (execute_en), .wb_en (wb_en),
        .pc_update_en (pc_update_en), .dmem_req (dmem_req), .dmem_we (dmem_we),
        .dmem_ack (dmem_ack), .state (state), .busy (busy), .halted (halted),
        .timeout_err (timeout_err), .cycle_count (cycle_count),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; clear_halt = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; instr_in = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; reg_w_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cycles  = 0;
        exp_retired = 0;
    endtask

    // Drives one instruction from FETCH through PCUPD and checks every cycle
    // against the trace derived from the stage rules.
    task automatic run_instr(input logic [INSTR_W-1:0] instr, input bit rd, input bit wr,
                             input bit wen, input int fwait, input int mwait,
                             input bit keep_run, input bit halt_at_exec);
        logic [3:0]  exp_q[$];
        logic [10:0] got_v, exp_v;
        logic [3:0]  e;
        int          fcnt = 0;
        int          mcnt = 0;
        repeat (fwait + 1) exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        exp_q.push_back(S_REGREAD);
        exp_q.push_back(S_EXECUTE);
        if (rd || wr) repeat (mwait + 1) exp_q.push_back(S_MEM);
        if (wen) exp_q.push_back(S_WB);
        exp_q.push_back(S_PCUPD);
        run = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            e = exp_q[i];
            checks++;
            if (state !== e) begin
                failures++;
                $display("FAIL seq_state instr=%h idx=%0d got=%0d exp=%0d", instr, i, state, e);
            end
            got_v = {imem_req, decode_en, regread_en, execute_en, dmem_req, dmem_we,
                     wb_en, pc_update_en, busy, halted, timeout_err};
            exp_v = {e == S_FETCH, e == S_DECODE, e == S_REGREAD, e == S_EXECUTE,
                     e == S_MEM, (e == S_MEM) && wr, e == S_WB, e == S_PCUPD,
                     1'b1, 1'b0, 1'b0};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL seq_outputs instr=%h idx=%0d got=%b exp=%b", instr, i, got_v, exp_v);
            end
            if (e == S_DECODE) begin
                checks++;
                if (instr_out !== instr) begin
                    failures++;
                    $display("FAIL instr_latch got=%h exp=%h", instr_out, instr);
                end
            end
            halt_req = halt_at_exec && (e == S_EXECUTE);
            imem_ack = (e == S_FETCH) ? (fcnt == fwait) : 1'($urandom_range(0, 1));
            dmem_ack = (e == S_MEM)   ? (mcnt == mwait) : 1'($urandom_range(0, 1));
            instr_in = (e == S_FETCH && fcnt == fwait) ? instr : INSTR_W'($urandom);
            if (e == S_EXECUTE) begin
                mem_rd = rd; mem_wr = wr; reg_w_en = wen;
            end else begin
                mem_rd = 1'($urandom_range(0, 1));
                mem_wr = 1'($urandom_range(0, 1));
                reg_w_en = 1'($urandom_range(0, 1));
            end
            if (e == S_FETCH) fcnt++;
            if (e == S_MEM)   mcnt++;
            if (e == S_PCUPD) run = keep_run;
        end
        exp_cycles  += exp_q.size();
        exp_retired += 1;
        $display("instr %h rd=%0d wr=%0d wen=%0d fwait=%0d mwait=%0d cycles=%0d",
                 instr, rd, wr, wen, fwait, mwait, exp_q.size());
    endtask

    task automatic test_reset();
        logic [11:0] got_v;
        do_reset();
        got_v = {imem_req, decode_en, regread_en, execute_en, wb_en, pc_update_en,
                 dmem_req, dmem_we, busy, halted, timeout_err, 1'b0};
        checks++;
        if (state !== S_IDLE || got_v !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs state=%0d outs=%b exp state=0 outs=0", state, got_v);
        end
        checks++;
        if (cycle_count !== 0 || retired_count !== 0 || instr_out !== 0) begin
            failures++;
            $display("FAIL reset_regs cyc=%0d ret=%0d instr=%h exp all 0",
                     cycle_count, retired_count, instr_out);
        end
        $display("reset done");
    endtask

    task automatic test_alu();
        do_reset();
        run_instr(8'hA5, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (state !== S_IDLE || retired_count !== 1 || cycle_count !== 6) begin
            failures++;
            $display("FAIL alu_counts state=%0d ret=%0d cyc=%0d exp 0/1/6",
                     state, retired_count, cycle_count);
        end
        checks++;
        if (instr_out !== 8'hA5) begin
            failures++;
            $display("FAIL alu_instr got=%h exp=a5", instr_out);
        end
    endtask

    task automatic test_load();
        do_reset();
        run_instr(8'h3C, 1'b1, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (cycle_count !== 10 || retired_count !== 1) begin
            failures++;
            $display("FAIL load_counts cyc=%0d ret=%0d exp 10/1", cycle_count, retired_count);
        end
    endtask

    task automatic test_store_branch();
        do_reset();
        run_instr(8'h5A, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        run_instr(8'hC3, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (cycle_count !== 11 || retired_count !== 2 || state !== S_IDLE) begin
            failures++;
            $display("FAIL store_branch cyc=%0d ret=%0d state=%0d exp 11/2/0",
                     cycle_count, retired_count, state);
        end
    endtask

    task automatic test_fetch_timeout();
        do_reset();
        run = 1'b1;
        for (int i = 0; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            checks++;
            if (state !== S_FETCH || imem_req !== 1'b1) begin
                failures++;
                $display("FAIL timeout_wait cycle=%0d state=%0d req=%b exp 1/1", i, state, imem_req);
            end
        end
        @(negedge clk);
        checks++;
        if (state !== S_HALT || timeout_err !== 1'b1 || halted !== 1'b1 ||
            imem_req !== 1'b0 || busy !== 1'b0 || cycle_count !== MAX_WAIT + 1) begin
            failures++;
            $display("FAIL timeout_halt state=%0d err=%b halted=%b req=%b busy=%b cyc=%0d exp 8/1/1/0/0/16",
                     state, timeout_err, halted, imem_req, busy, cycle_count);
        end
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        checks++;
        if (state !== S_HALT) begin
            failures++;
            $display("FAIL halt_holds state=%0d exp=8", state);
        end
        clear_halt = 1'b1;
        run = 1'b0;
        @(negedge clk);
        clear_halt = 1'b0;
        checks++;
        if (state !== S_IDLE || timeout_err !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL clear_halt state=%0d err=%b halted=%b exp 0/0/0", state, timeout_err, halted);
        end
        $display("fetch timeout sequence done");
    endtask

    task automatic test_boundary();
        do_reset();
        run_instr(8'h81, 1'b1, 1'b0, 1'b1, MAX_WAIT, MAX_WAIT, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (state !== S_IDLE || timeout_err !== 1'b0 || retired_count !== 1) begin
            failures++;
            $display("FAIL ack_at_limit state=%0d err=%b ret=%0d exp 0/0/1",
                     state, timeout_err, retired_count);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run_instr(8'h77, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (state !== S_HALT || halted !== 1'b1 || retired_count !== 1) begin
            failures++;
            $display("FAIL halt_at_boundary state=%0d halted=%b ret=%0d exp 8/1/1",
                     state, halted, retired_count);
        end
        clear_halt = 1'b1;
        run = 1'b0;
        @(negedge clk);
        clear_halt = 1'b0;
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        checks++;
        if (state !== S_HALT) begin
            failures++;
            $display("FAIL halt_from_idle state=%0d exp=8", state);
        end
        clear_halt = 1'b1;
        @(negedge clk);
        clear_halt = 1'b0;
        run_instr(8'h12, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (state !== S_IDLE) begin
            failures++;
            $display("FAIL pending_cleared state=%0d exp=0", state);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run = 1'b1; imem_ack = 1'b1; instr_in = 8'hE7;
        mem_rd = 1'b1; mem_wr = 1'b0; reg_w_en = 1'b1; dmem_ack = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (state !== S_MEM || dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_mem state=%0d dreq=%b exp 5/1", state, dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== S_IDLE || dmem_req !== 1'b0 || cycle_count !== 0 || instr_out !== 0) begin
            failures++;
            $display("FAIL async_reset state=%0d dreq=%b cyc=%0d instr=%h exp all 0",
                     state, dmem_req, cycle_count, instr_out);
        end
        run = 1'b0; imem_ack = 1'b0; mem_rd = 1'b0; reg_w_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset during MEM done");
    endtask

    task automatic test_random();
        bit rd, wr, wen, keep;
        int fw, mw;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = !rd && ($urandom_range(0, 2) == 0);
            wen = 1'($urandom_range(0, 1));
            fw  = ($urandom_range(0, 7) == 0) ? MAX_WAIT : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 7) == 0) ? MAX_WAIT : $urandom_range(0, 3);
            keep = (n != 29) && ($urandom_range(0, 3) != 0);
            run_instr(INSTR_W'($urandom), rd, wr, wen, fw, mw, keep, 1'b0);
            if (!keep) begin
                @(negedge clk);
                checks++;
                if (state !== S_IDLE) begin
                    failures++;
                    $display("FAIL rand_idle n=%0d state=%0d exp=0", n, state);
                end
            end
        end
        checks++;
        if (retired_count !== CNT_W'(exp_retired) || cycle_count !== CNT_W'(exp_cycles)) begin
            failures++;
            $display("FAIL rand_counters ret=%0d cyc=%0d exp ret=%0d cyc=%0d",
                     retired_count, cycle_count, exp_retired, exp_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_branch();
        test_fetch_timeout();
        test_boundary();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised, clocked successor to the core's multicycle state sequencing.
- Steps each instruction through fetch, decode, register read, execute, optional data-memory access, optional writeback and PC update.
- Emits one-cycle stage strobes to the control unit, ALU, register file and program counter.
- Adds req/ack memory handshakes with timeout, stage skipping, halt/run control and performance counters.

Parameters:
- INSTR_W, 8: instruction width in bits.
- MAX_WAIT, 15: number of extra cycles a memory request may wait for ack before a timeout.
- CNT_W, 16: width of the cycle and retired-instruction counters.

Ports:
- clk  in  1  Single system clock; all state changes on its rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- run  in  1  Level signal; high starts and keeps sequencing.
- halt_req  in  1  Pulse; requests a halt at the next instruction boundary.
- clear_halt  in  1  Pulse; leaves the HALT state.
- imem_req  out  1  Instruction fetch request.
- imem_ack  in  1  Fetch data valid on instr_in.
- instr_in  in  INSTR_W  Instruction from instruction memory.
- instr_out  out  INSTR_W  Latched current instruction.
- mem_rd, mem_wr, reg_w_en  in  1 each  Control-unit flags.
- decode_en, regread_en, execute_en, wb_en, pc_update_en  out  1 each  Stage strobes.
- dmem_req  out  1  Data memory request.
- dmem_we  out  1  Write qualifier for dmem_req.
- dmem_ack  in  1  Data memory completion.
- state  out  4  Current state encoding.
- busy  out  1  State is neither IDLE nor HALT.
- halted  out  1  State is HALT.
- timeout_err  out  1  Sticky timeout flag.
- cycle_count, retired_count  out  CNT_W each  Performance counters.

Behaviour:
- Reset: state=IDLE. All strobes, imem_req, dmem_req, dmem_we, timeout_err, halted, counters and instr_out are 0. The internal halt_pending flag is 0.
- States (4-bit): IDLE=0, FETCH=1, DECODE=2, REGREAD=3, EXECUTE=4, MEM=5, WB=6, PCUPD=7, HALT=8.
- Strobes are Moore outputs. decode_en, regread_en, execute_en, wb_en and pc_update_en are each high for exactly the one cycle spent in the matching state.
- IDLE: when run=1, go to FETCH.
- FETCH: imem_req=1 for the whole state.
  - When imem_ack=1: latch instr_in into instr_out and go to DECODE.
  - Ack is accepted in the first FETCH cycle (zero-wait).
- DECODE, then REGREAD, then EXECUTE: one cycle each.
- EXECUTE samples mem_rd, mem_wr and reg_w_en into internal registers.
  - mem_rd or mem_wr set: go to MEM.
  - Else reg_w_en set: go to WB.
  - Else: go to PCUPD.
- MEM: dmem_req=1 and dmem_we=latched mem_wr. On dmem_ack, go to WB if latched reg_w_en is set, else PCUPD.
- WB: go to PCUPD.
- PCUPD: retired_count increments (wraps). Next state:
  - halt_pending set: HALT.
  - Else run=0: IDLE.
  - Else: FETCH.
- halt_req in any cycle sets halt_pending. halt_pending takes effect only at PCUPD, or immediately if halt_req arrives while in IDLE (IDLE goes to HALT).
- Wait timer:
  - Cleared on entry to FETCH or MEM; increments each cycle the awaited ack is low.
  - If the ack is still low while the timer equals MAX_WAIT, go to HALT and set timeout_err.
  - A request therefore gets MAX_WAIT+1 cycles in total.
  - An ack arriving in the same cycle as the timer reaching MAX_WAIT wins; the handshake completes normally.
- Acks received outside their own state are ignored.
- HALT: halted=1 and all requests drop.
  - clear_halt goes to IDLE and clears halt_pending and timeout_err.
  - run and halt_req are ignored while in HALT.
- cycle_count increments every cycle in which busy=1 (wraps).
- Asynchronous reset mid-instruction drops requests immediately and returns everything to its reset value.
- Cycle counts from FETCH to PCUPD inclusive, zero-wait memories:
  - ALU instruction with writeback: 6 cycles.
  - Load: 7 cycles.
  - Store: 6 cycles.
  - Branch or jump (no memory, no writeback): 5 cycles.

Decomposition:
- Package cpu_seq_pkg holds the state encoding localparams and the STATE_W=4 constant.
- One sub-module, seq_wait_timer: the parametrised MAX_WAIT counter with clear, increment and expired outputs.

Test Plan:
- ALU instruction, run=1, imem_ack on first FETCH cycle, reg_w_en=1 -> strobes fire in order over 6 cycles; retired_count=1; instr_out equals instr_in (e.g. 8'hA5).
- Load with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then wb_en, then pc_update_en; cycle_count=10.
- Store (mem_wr=1, reg_w_en=0) -> MEM then PCUPD with no wb_en pulse; dmem_we=1 throughout MEM.
- imem_ack never asserted, MAX_WAIT=15 -> after 16 FETCH cycles state=8, timeout_err=1, halted=1. Then clear_halt -> state=0 and timeout_err=0.
- halt_req pulsed during EXECUTE -> instruction completes and retired_count increments, then state=HALT. A second halt_req in IDLE goes to HALT directly.
- rst_n low during MEM with dmem_req=1 -> dmem_req=0 and state=0 immediately, without waiting for a clock edge.
